dip_switch_ctrl: RTL and testbench

Parametrised memory-mapped DIP-switch peripheral on the bridge's device bus, generalising the fixed two-word switch reader. Takes `N_BYTES` active-low 8-bit switch groups and synchronises and debounces each one. It exposes the settled, inverted values as 32-bit read words, and latches per-group change flags. The flags can raise a maskable interrupt to the CPU's external-interrupt input.

---
 rtl/dip_switch_ctrl.sv | 119 +++++++++++
 tb/tb_dip_switch_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dip_switch_ctrl.sv
// dip_switch_ctrl: synchronised, debounced active-low DIP-switch groups on the
// device bus, with sticky per-group change flags and a maskable level IRQ.
module dip_switch_ctrl #(
    parameter int          N_BYTES   = 8,
    parameter int          DEBOUNCE  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h7f60
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Addr,
    input  logic                 WE,
    input  logic [31:0]          WD,
    input  logic [8*N_BYTES-1:0] switch,
    output logic [31:0]          DSout,
    output logic                 IRQ
);
    localparam int            W       = N_BYTES / 4;
    localparam int            CW      = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
    localparam logic [31:0]   VALID   = 32'hffff_ffff >> (32 - N_BYTES);

    logic [31:0] off;
    logic [29:0] idx;
    logic        aligned;
    logic        sel_status;
    logic        sel_en;

    assign off        = Addr - BASE_ADDR;
    assign idx        = off[31:2];
    assign aligned    = (off[1:0] == 2'b00);
    assign sel_status = aligned && (idx == 30'(W));
    assign sel_en     = aligned && (idx == 30'(W + 1));

    logic [8*N_BYTES-1:0] sync1;
    logic [8*N_BYTES-1:0] sync2;
    logic [8*N_BYTES-1:0] s;
    logic [8*N_BYTES-1:0] s_prev;
    logic [8*N_BYTES-1:0] stable;
    logic [N_BYTES-1:0]   commit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            s_prev <= '0;
        end else begin
            sync1  <= switch;
            sync2  <= sync1;
            s_prev <= s;
        end
    end

    assign s = ~sync2;

    // A group only counts while its value is steady and differs from stable.
    for (genvar g = 0; g < N_BYTES; g++) begin : g_grp
        logic [7:0]    sg;
        logic [7:0]    pg;
        logic [7:0]    st;
        logic [CW-1:0] cnt;
        logic          hold;

        assign sg        = s[8*g +: 8];
        assign pg        = s_prev[8*g +: 8];
        assign hold      = (sg == pg) && (sg != st);
        assign commit[g] = hold && (cnt == CNT_MAX);
        assign stable[8*g +: 8] = st;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
                st  <= '0;
            end else if (!hold) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                st  <= sg;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    logic [31:0] status;
    logic [31:0] irq_en;
    logic [31:0] clr;

    assign clr = (WE && sel_status) ? WD : '0;

    // Commit is OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status <= '0;
            irq_en <= '0;
        end else begin
            status <= ((status & ~clr) | 32'(commit)) & VALID;
            if (WE && sel_en) begin
                irq_en <= WD & VALID;
            end
        end
    end

    assign IRQ = |(status & irq_en);

    always_comb begin
        DSout = '0;
        if (sel_status) begin
            DSout = status;
        end else if (sel_en) begin
            DSout = irq_en;
        end else if (aligned) begin
            for (int k = 0; k < W; k++) begin
                if (idx == 30'(k)) begin
                    DSout = stable[32*k +: 32];
                end
            end
        end
    end
endmodule

// File: tb/tb_dip_switch_ctrl.sv
// tb_dip_switch_ctrl: directed bench for dip_switch_ctrl with
// N_BYTES = 12 and DEBOUNCE = 4.
module tb_dip_switch_ctrl;
    localparam int          NB   = 12;
    localparam logic [31:0] B    = 32'h7f60;
    localparam logic [31:0] A_D0 = B;
    localparam logic [31:0] A_D1 = B + 4;
    localparam logic [31:0] A_D2 = B + 8;
    localparam logic [31:0] A_ST = B + 12;
    localparam logic [31:0] A_EN = B + 16;
    localparam logic [31:0] A_NX = B + 20;

    logic            clk    = 1'b0;
    logic            reset  = 1'b0;
    logic            WE     = 1'b0;
    logic [31:0]     Addr   = '0;
    logic [31:0]     WD     = '0;
    logic [8*NB-1:0] switch = '1;
    logic [31:0]     DSout;
    logic            IRQ;

    int pass  = 0;
    int total = 0;

    dip_switch_ctrl #(
        .N_BYTES  (NB),
        .DEBOUNCE (4),
        .BASE_ADDR(B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .WD    (WD),
        .switch(switch),
        .DSout (DSout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [31:0] a);
        Addr = a;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a;
        WD   = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic set_grp(input int g, input logic [7:0] v);
        switch[8*g +: 8] = v;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        switch = '1;
        ticks(2);
        rd(A_D0);
        total++;
        if (DSout !== 32'h0) $display("FAIL reset_data0 got %h want 0", DSout);
        else pass++;
        rd(A_ST);
        total++;
        if (DSout !== 32'h0) $display("FAIL reset_status got %h want 0", DSout);
        else pass++;
        rd(A_EN);
        total++;
        if (DSout !== 32'h0) $display("FAIL reset_irq_en got %h want 0", DSout);
        else pass++;
        total++;
        if (IRQ !== 1'b0) $display("FAIL reset_irq got %b want 0", IRQ);
        else pass++;
        reset = 1'b1;
        set_grp(0, 8'hFE);
        Addr = A_D0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            total++;
            if (DSout !== 32'h0)
                $display("FAIL latency_early edge %0d got %h want 0", e, DSout);
            else pass++;
        end
        tick();
        total++;
        if (DSout !== 32'h1) $display("FAIL latency_commit got %h want 1", DSout);
        else pass++;
        rd(A_ST);
        total++;
        if (DSout !== 32'h1) $display("FAIL latency_status got %h want 1", DSout);
        else pass++;
    endtask

    task automatic test_release();
        wr(A_ST, 32'h1);
        rd(A_ST);
        total++;
        if (DSout !== 32'h0) $display("FAIL w1c_status got %h want 0", DSout);
        else pass++;
        set_grp(0, 8'hFF);
        ticks(6);
        rd(A_D0);
        total++;
        if (DSout !== 32'h1) $display("FAIL release_early got %h want 1", DSout);
        else pass++;
        tick();
        total++;
        if (DSout !== 32'h0) $display("FAIL release_data got %h want 0", DSout);
        else pass++;
        rd(A_ST);
        total++;
        if (DSout !== 32'h1) $display("FAIL release_status got %h want 1", DSout);
        else pass++;
        wr(A_ST, 32'h1);
    endtask

    task automatic test_glitch();
        wr(A_EN, 32'h8);
        set_grp(3, 8'h00);
        ticks(3);
        set_grp(3, 8'hFF);
        for (int c = 0; c < 12; c++) begin
            tick();
            rd(A_D0);
            total++;
            if (DSout !== 32'h0)
                $display("FAIL glitch_data cyc %0d got %h want 0", c, DSout);
            else pass++;
            rd(A_ST);
            total++;
            if (DSout !== 32'h0)
                $display("FAIL glitch_status cyc %0d got %h want 0", c, DSout);
            else pass++;
            total++;
            if (IRQ !== 1'b0)
                $display("FAIL glitch_irq cyc %0d got %b want 0", c, IRQ);
            else pass++;
        end
        wr(A_EN, 32'h0);
    endtask

    task automatic test_irq_mask();
        set_grp(5, 8'h00);
        ticks(7);
        rd(A_D1);
        total++;
        if (DSout !== 32'h0000_FF00) $display("FAIL g5_data got %h want 0000ff00", DSout);
        else pass++;
        rd(A_ST);
        total++;
        if (DSout !== 32'h20) $display("FAIL g5_status got %h want 20", DSout);
        else pass++;
        total++;
        if (IRQ !== 1'b0) $display("FAIL g5_irq_masked got %b want 0", IRQ);
        else pass++;
        wr(A_EN, 32'h20);
        total++;
        if (IRQ !== 1'b1) $display("FAIL irq_enable got %b want 1", IRQ);
        else pass++;
        rd(A_EN);
        total++;
        if (DSout !== 32'h20) $display("FAIL irq_en_readback got %h want 20", DSout);
        else pass++;
        wr(A_ST, 32'h20);
        total++;
        if (IRQ !== 1'b0) $display("FAIL irq_after_clear got %b want 0", IRQ);
        else pass++;
        rd(A_ST);
        total++;
        if (DSout !== 32'h0) $display("FAIL status_after_clear got %h want 0", DSout);
        else pass++;
        set_grp(5, 8'hFF);
        ticks(7);
        rd(A_D1);
        total++;
        if (DSout !== 32'h0) $display("FAIL g5_release_data got %h want 0", DSout);
        else pass++;
        total++;
        if (IRQ !== 1'b1) $display("FAIL g5_release_irq got %b want 1", IRQ);
        else pass++;
        wr(A_EN, 32'h0);
        total++;
        if (IRQ !== 1'b0) $display("FAIL irq_after_disable got %b want 0", IRQ);
        else pass++;
        rd(A_ST);
        total++;
        if (DSout !== 32'h20) $display("FAIL status_kept got %h want 20", DSout);
        else pass++;
        wr(A_ST, 32'h20);
    endtask

    task automatic test_set_wins();
        set_grp(2, 8'h00);
        ticks(6);
        rd(A_ST);
        total++;
        if (DSout !== 32'h0) $display("FAIL set_wins_pre got %h want 0", DSout);
        else pass++;
        wr(A_ST, 32'h4);
        rd(A_ST);
        total++;
        if (DSout !== 32'h4) $display("FAIL set_wins got %h want 4", DSout);
        else pass++;
        rd(A_D0);
        total++;
        if (DSout !== 32'h00FF_0000) $display("FAIL g2_data got %h want 00ff0000", DSout);
        else pass++;
        wr(A_ST, 32'h4);
        rd(A_ST);
        total++;
        if (DSout !== 32'h0) $display("FAIL set_wins_clear got %h want 0", DSout);
        else pass++;
    endtask

    task automatic test_map();
        switch = '1;
        set_grp(9, 8'h0F);
        ticks(7);
        rd(A_D0);
        total++;
        if (DSout !== 32'h0) $display("FAIL map_d0 got %h want 0", DSout);
        else pass++;
        rd(A_D1);
        total++;
        if (DSout !== 32'h0) $display("FAIL map_d1 got %h want 0", DSout);
        else pass++;
        rd(A_D2);
        total++;
        if (DSout !== 32'h0000_F000) $display("FAIL map_d2 got %h want 0000f000", DSout);
        else pass++;
        rd(A_ST);
        total++;
        if (DSout !== 32'h204) $display("FAIL map_status got %h want 204", DSout);
        else pass++;
        rd(A_EN);
        total++;
        if (DSout !== 32'h0) $display("FAIL map_irq_en got %h want 0", DSout);
        else pass++;
        rd(A_NX);
        total++;
        if (DSout !== 32'h0) $display("FAIL map_outside got %h want 0", DSout);
        else pass++;
        rd(B + 9);
        total++;
        if (DSout !== 32'h0) $display("FAIL map_unaligned got %h want 0", DSout);
        else pass++;
        wr(A_D2, 32'h1234_5678);
        rd(A_D2);
        total++;
        if (DSout !== 32'h0000_F000) $display("FAIL data_ro got %h want 0000f000", DSout);
        else pass++;
        wr(A_NX, 32'hFFFF_FFFF);
        rd(A_ST);
        total++;
        if (DSout !== 32'h204) $display("FAIL outside_wr_status got %h want 204", DSout);
        else pass++;
        rd(A_EN);
        total++;
        if (DSout !== 32'h0) $display("FAIL outside_wr_en got %h want 0", DSout);
        else pass++;
        wr(A_EN, 32'hFFFF_FFFF);
        rd(A_EN);
        total++;
        if (DSout !== 32'h0000_0FFF) $display("FAIL irq_en_mask got %h want 00000fff", DSout);
        else pass++;
        total++;
        if (IRQ !== 1'b1) $display("FAIL map_irq got %b want 1", IRQ);
        else pass++;
    endtask

    task automatic test_async_reset();
        rd(A_D2);
        total++;
        if (DSout !== 32'h0000_F000) $display("FAIL areset_pre_data got %h want 0000f000", DSout);
        else pass++;
        total++;
        if (IRQ !== 1'b1) $display("FAIL areset_pre_irq got %b want 1", IRQ);
        else pass++;
        set_grp(0, 8'hFE);
        ticks(4);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (DSout !== 32'h0) $display("FAIL areset_data got %h want 0", DSout);
        else pass++;
        total++;
        if (IRQ !== 1'b0) $display("FAIL areset_irq got %b want 0", IRQ);
        else pass++;
        rd(A_ST);
        total++;
        if (DSout !== 32'h0) $display("FAIL areset_status got %h want 0", DSout);
        else pass++;
        ticks(2);
        rd(A_D2);
        total++;
        if (DSout !== 32'h0) $display("FAIL areset_held got %h want 0", DSout);
        else pass++;
        reset = 1'b1;
        Addr  = A_D0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            total++;
            if (DSout !== 32'h0)
                $display("FAIL restart_early edge %0d got %h want 0", e, DSout);
            else pass++;
        end
        tick();
        total++;
        if (DSout !== 32'h1) $display("FAIL restart_commit got %h want 1", DSout);
        else pass++;
        rd(A_D2);
        total++;
        if (DSout !== 32'h0000_F000) $display("FAIL restart_d2 got %h want 0000f000", DSout);
        else pass++;
        rd(A_ST);
        total++;
        if (DSout !== 32'h201) $display("FAIL restart_status got %h want 201", DSout);
        else pass++;
        total++;
        if (IRQ !== 1'b0) $display("FAIL restart_irq got %b want 0", IRQ);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_release();
        test_glitch();
        test_irq_mask();
        test_set_wins();
        test_map();
        test_async_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
